// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode that
// accepts and presents up to SUPER_SCALAR_WIDTH instructions per cycle.
module fetch_queue #(
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int SUPER_SCALAR_WIDTH = 2,
    parameter int DEPTH              = 8
) (
    input  logic                                         clk_in,
    input  logic                                         rst_N_in,
    input  logic                                         enq_valid_in,
    input  logic [$clog2(SUPER_SCALAR_WIDTH+1)-1:0]      enq_count_in,
    input  logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] enq_instr_in,
    input  logic [63:0]                                  enq_pc_in,
    output logic                                         enq_ready_out,
    input  logic                                         flush_in,
    output logic                                         deq_valid_out,
    output logic [$clog2(SUPER_SCALAR_WIDTH+1)-1:0]      deq_count_out,
    output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] deq_instr_out,
    output logic [SUPER_SCALAR_WIDTH*64-1:0]             deq_pc_out,
    input  logic                                         deq_ready_in,
    output logic [$clog2(DEPTH+1)-1:0]                   occupancy_out
);

    localparam int W  = SUPER_SCALAR_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [OW-1:0] r_occ;
    logic [IW-1:0] r_mem_instr [DEPTH];
    logic [63:0]   r_mem_pc    [DEPTH];

    logic [OW-1:0] w_free;
    logic [CW-1:0] w_enq_cnt;
    logic [CW-1:0] w_deq_cnt;
    logic          w_enq_fire;
    logic          w_deq_fire;
    logic [OW-1:0] w_enq_add;
    logic [OW-1:0] w_deq_sub;

    // Ready depends only on registered occupancy, never on the consumer.
    assign w_free        = OW'(DEPTH) - r_occ;
    assign enq_ready_out = (w_free >= OW'(W));

    assign w_enq_cnt  = (enq_count_in > CW'(W)) ? CW'(W) : enq_count_in;
    assign w_enq_fire = enq_valid_in & enq_ready_out & (w_enq_cnt != '0) & ~flush_in;

    assign w_deq_cnt     = (r_occ >= OW'(W)) ? CW'(W) : CW'(r_occ);
    assign deq_valid_out = (r_occ != '0);
    assign deq_count_out = w_deq_cnt;
    assign w_deq_fire    = deq_valid_out & deq_ready_in & ~flush_in;

    assign w_enq_add = w_enq_fire ? OW'(w_enq_cnt) : '0;
    assign w_deq_sub = w_deq_fire ? OW'(w_deq_cnt) : '0;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush_in) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_tail <= r_tail + PW'(w_enq_add);
            r_head <= r_head + PW'(w_deq_sub);
            r_occ  <= r_occ + w_enq_add - w_deq_sub;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < W; i++) begin
            if (w_enq_fire && (CW'(i) < w_enq_cnt)) begin
                r_mem_instr[r_tail + PW'(i)] <= enq_instr_in[i*IW +: IW];
                r_mem_pc[r_tail + PW'(i)]    <= enq_pc_in + 64'(4 * i);
            end
        end
    end

    always_comb begin
        deq_instr_out = '0;
        deq_pc_out    = '0;
        for (int i = 0; i < W; i++) begin
            if (CW'(i) < w_deq_cnt) begin
                deq_instr_out[i*IW +: IW] = r_mem_instr[r_head + PW'(i)];
                deq_pc_out[i*64 +: 64]    = r_mem_pc[r_head + PW'(i)];
            end
        end
    end

    assign occupancy_out = r_occ;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with default parameters (IW=32, W=2, DEPTH=8).
module tb_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        enq_valid_in;
    logic [1:0]  enq_count_in;
    logic [63:0] enq_instr_in;
    logic [63:0] enq_pc_in;
    logic        enq_ready_out;
    logic        flush_in;
    logic        deq_valid_out;
    logic [1:0]  deq_count_out;
    logic [63:0] deq_instr_out;
    logic [127:0] deq_pc_out;
    logic        deq_ready_in;
    logic [3:0]  occupancy_out;

    int n_total = 0;
    int n_bad   = 0;

    fetch_queue #(
        .INSTRUCTION_WIDTH (32),
        .SUPER_SCALAR_WIDTH(2),
        .DEPTH             (8)
    ) dut (
        .clk_in        (clk_in),
        .rst_N_in      (rst_N_in),
        .enq_valid_in  (enq_valid_in),
        .enq_count_in  (enq_count_in),
        .enq_instr_in  (enq_instr_in),
        .enq_pc_in     (enq_pc_in),
        .enq_ready_out (enq_ready_out),
        .flush_in      (flush_in),
        .deq_valid_out (deq_valid_out),
        .deq_count_out (deq_count_out),
        .deq_instr_out (deq_instr_out),
        .deq_pc_out    (deq_pc_out),
        .deq_ready_in  (deq_ready_in),
        .occupancy_out (occupancy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enq_set(input logic v, input logic [1:0] cnt, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] pc);
        enq_valid_in = v;
        enq_count_in = cnt;
        enq_instr_in = {b, a};
        enq_pc_in    = pc;
    endtask

    initial begin
        int sent;
        int got;
        logic [63:0] exp_pc;
        logic [63:0] pc0;
        logic [63:0] pc1;

        rst_N_in     = 1'b0;
        flush_in     = 1'b0;
        deq_ready_in = 1'b0;
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        repeat (2) @(negedge clk_in);

        chk("rst_deq_valid", 64'(deq_valid_out), 64'd0);
        chk("rst_deq_count", 64'(deq_count_out), 64'd0);
        chk("rst_occ", 64'(occupancy_out), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready_out), 64'd1);
        chk("rst_deq_pc", 64'(deq_pc_out != '0), 64'd0);
        chk("rst_deq_instr", deq_instr_out, 64'd0);
        rst_N_in = 1'b1;
        step();

        // first group, and no same-cycle bypass
        enq_set(1'b1, 2'd2, 32'hAAAA_0001, 32'hBBBB_0002, 64'h1000);
        #1;
        chk("nobypass_valid", 64'(deq_valid_out), 64'd0);
        step();
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("g1_valid", 64'(deq_valid_out), 64'd1);
        chk("g1_count", 64'(deq_count_out), 64'd2);
        chk("g1_pc0", deq_pc_out[63:0], 64'h1000);
        chk("g1_pc1", deq_pc_out[127:64], 64'h1004);
        chk("g1_instr0", 64'(deq_instr_out[31:0]), 64'hAAAA_0001);
        chk("g1_instr1", 64'(deq_instr_out[63:32]), 64'hBBBB_0002);
        chk("g1_occ", 64'(occupancy_out), 64'd2);

        // fill to DEPTH
        for (int g = 1; g < 4; g++) begin
            enq_set(1'b1, 2'd2, 32'h100 + 32'(g), 32'h200 + 32'(g), 64'h1000 + 64'(8 * g));
            step();
        end
        chk("full_occ", 64'(occupancy_out), 64'd8);
        chk("full_ready", 64'(enq_ready_out), 64'd0);
        enq_set(1'b1, 2'd2, 32'hDEAD, 32'hBEEF, 64'h9000);
        step();
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("full_reject_occ", 64'(occupancy_out), 64'd8);
        chk("full_head_pc", deq_pc_out[63:0], 64'h1000);

        // drain in order
        deq_ready_in = 1'b1;
        for (int g = 0; g < 4; g++) begin
            chk("drain_pc0", deq_pc_out[63:0], 64'h1000 + 64'(8 * g));
            chk("drain_pc1", deq_pc_out[127:64], 64'h1004 + 64'(8 * g));
            step();
        end
        deq_ready_in = 1'b0;
        chk("drain_occ", 64'(occupancy_out), 64'd0);
        chk("drain_valid", 64'(deq_valid_out), 64'd0);

        // simultaneous enqueue and dequeue at occupancy 3
        enq_set(1'b1, 2'd1, 32'h2000, 32'h0, 64'h2000);
        step();
        enq_set(1'b1, 2'd2, 32'h2004, 32'h2008, 64'h2004);
        step();
        chk("sim_pre_occ", 64'(occupancy_out), 64'd3);
        enq_set(1'b1, 2'd2, 32'h3000, 32'h3004, 64'h3000);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("sim_occ", 64'(occupancy_out), 64'd3);
        chk("sim_pc0", deq_pc_out[63:0], 64'h2008);
        chk("sim_instr0", 64'(deq_instr_out[31:0]), 64'h2008);
        chk("sim_pc1", deq_pc_out[127:64], 64'h3000);

        // flush at occupancy 5 overrides enqueue and dequeue
        enq_set(1'b1, 2'd2, 32'h4000, 32'h4004, 64'h4000);
        step();
        chk("pre_flush_occ", 64'(occupancy_out), 64'd5);
        enq_set(1'b1, 2'd2, 32'h4100, 32'h4104, 64'h4100);
        deq_ready_in = 1'b1;
        flush_in     = 1'b1;
        step();
        flush_in     = 1'b0;
        deq_ready_in = 1'b0;
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("flush_occ", 64'(occupancy_out), 64'd0);
        chk("flush_valid", 64'(deq_valid_out), 64'd0);
        step();
        chk("flush_drop_occ", 64'(occupancy_out), 64'd0);

        // count > W clamps, count 0 is a no-op
        enq_set(1'b1, 2'd3, 32'h5000, 32'h5004, 64'h5000);
        step();
        chk("clamp_occ", 64'(occupancy_out), 64'd2);
        chk("clamp_pc1", deq_pc_out[127:64], 64'h5004);
        enq_set(1'b1, 2'd0, 32'hFFFF, 32'hFFFF, 64'h7000);
        step();
        chk("zero_cnt_occ", 64'(occupancy_out), 64'd2);
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;
        chk("clamp_drain_occ", 64'(occupancy_out), 64'd0);

        // partial presentation zeroes unused slot
        enq_set(1'b1, 2'd1, 32'h66, 32'h77, 64'h6000);
        step();
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("part_count", 64'(deq_count_out), 64'd1);
        chk("part_pc0", deq_pc_out[63:0], 64'h6000);
        chk("part_pc1_zero", deq_pc_out[127:64], 64'h0);
        chk("part_instr1_zero", 64'(deq_instr_out[63:32]), 64'h0);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;

        // 20 single-instruction groups across pointer wrap
        sent   = 0;
        got    = 0;
        exp_pc = 64'h0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            if (sent < 20 && enq_ready_out) begin
                enq_set(1'b1, 2'd1, 32'hC0DE_0000 + 32'(sent), 32'h0, 64'(4 * sent));
                sent++;
            end else begin
                enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
            end
            deq_ready_in = ((c % 3) != 0);
            #1;
            if (deq_valid_out && deq_ready_in) begin
                pc0 = deq_pc_out[63:0];
                pc1 = deq_pc_out[127:64];
                chk("wrap_pc0", pc0, exp_pc);
                chk("wrap_instr0", 64'(deq_instr_out[31:0]), 64'hC0DE_0000 + (exp_pc >> 2));
                exp_pc += 4;
                got++;
                if (deq_count_out == 2'd2) begin
                    chk("wrap_pc1", pc1, exp_pc);
                    exp_pc += 4;
                    got++;
                end
            end
            step();
        end
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        deq_ready_in = 1'b0;
        chk("wrap_count", 64'(got), 64'd20);
        chk("wrap_occ", 64'(occupancy_out), 64'd0);

        // async reset mid-cycle at occupancy 6
        for (int g = 0; g < 3; g++) begin
            enq_set(1'b1, 2'd2, 32'h8000, 32'h8004, 64'h8000 + 64'(8 * g));
            step();
        end
        enq_set(1'b0, 2'd0, 32'h0, 32'h0, 64'h0);
        chk("pre_rst_occ", 64'(occupancy_out), 64'd6);
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("arst_occ", 64'(occupancy_out), 64'd0);
        chk("arst_valid", 64'(deq_valid_out), 64'd0);
        chk("arst_count", 64'(deq_count_out), 64'd0);
        chk("arst_ready", 64'(enq_ready_out), 64'd1);
        chk("arst_pc0", deq_pc_out[63:0], 64'h0);
        #7;
        rst_N_in = 1'b1;
        step();
        chk("post_rst_occ", 64'(occupancy_out), 64'd0);
        chk("post_rst_valid", 64'(deq_valid_out), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
